// File: rtl/tff_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// tff_updown_counter_pkg : shared mode constants and modulus-to-width helper
// Revision: 1.0
// ============================================================================
package tff_updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (64'(value) > (64'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tff_updown_counter_cell.sv
`default_nettype none
// ============================================================================
// tff_cell : single-bit T flip-flop, synchronous active-high reset to 0
// Revision: 1.0
// ============================================================================
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (rst)    q <= 1'b0;
    else if (t) q <= ~q;
  end

  assign qb = ~q;

endmodule
`default_nettype wire

// File: rtl/tff_updown_counter.sv
`default_nettype none
// ============================================================================
// tff_updown_counter : modulo up/down counter with load, wrap/saturate mode
// Revision: 1.0
// ============================================================================
module tff_updown_counter
  import tff_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   nxt_ext;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             at_last;
  logic             at_zero;
  logic             wrap_nxt;

  assign q_ext    = {1'b0, q};
  assign load_ext = {1'b0, load_val};
  assign at_last  = (q_ext == LAST);
  assign at_zero  = (q_ext == '0);

  always_comb begin
    nxt_ext  = q_ext;
    wrap_nxt = 1'b0;
    if (load) begin
      nxt_ext = (load_ext > LAST) ? LAST : load_ext;
    end else if (en) begin
      if (up_dn) begin
        if (!at_last) begin
          nxt_ext = q_ext + 1'b1;
        end else if (SATURATE != MODE_SAT) begin
          nxt_ext  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          nxt_ext = q_ext - 1'b1;
        end else if (SATURATE != MODE_SAT) begin
          nxt_ext  = LAST;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  assign nxt = nxt_ext[WIDTH-1:0];
  // Toggle exactly the bits that differ, so loads and non-power-of-2 wraps
  // are expressed purely as T-flop toggles.
  assign t   = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_nxt;
  end

  assign tc = en & ((up_dn & at_last) | (~up_dn & at_zero));

endmodule
`default_nettype wire

// File: tb/tb_tff_updown_counter.sv
`default_nettype none
// ============================================================================
// tb_tff_updown_counter : directed and random checks on three configurations
// Revision: 1.0
// ============================================================================
module tb_tff_updown_counter;
  import tff_updown_counter_pkg::*;

  localparam int W10 = clog2(10);

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [7:0] load_val;

  logic [7:0]     q8, qb8;
  logic           tc8, wrap8;
  logic [W10-1:0] q10w, qb10w, q10s, qb10s;
  logic           tc10w, wrap10w, tc10s, wrap10s;

  int n_checks = 0;
  int n_pass   = 0;

  int m_q   [3];
  int m_wrap[3];
  int c_mod [3] = '{256, 10, 10};
  int c_sat [3] = '{0, 0, 1};
  int c_mask[3] = '{255, 15, 15};

  always #5 clk = ~clk;

  tff_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(MODE_WRAP)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q8), .qb(qb8), .tc(tc8), .wrap(wrap8)
  );

  tff_updown_counter #(.WIDTH(W10), .MODULUS(10), .SATURATE(MODE_WRAP)) u_dut10w (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[W10-1:0]), .q(q10w), .qb(qb10w), .tc(tc10w), .wrap(wrap10w)
  );

  tff_updown_counter #(.WIDTH(W10), .MODULUS(10), .SATURATE(MODE_SAT)) u_dut10s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[W10-1:0]), .q(q10s), .qb(qb10s), .tc(tc10s), .wrap(wrap10s)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int model_tc(input int k);
    if (!en) return 0;
    if (up_dn) return (m_q[k] == c_mod[k] - 1) ? 1 : 0;
    return (m_q[k] == 0) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int lv;
    for (int k = 0; k < 3; k++) begin
      m_wrap[k] = 0;
      if (rst) begin
        m_q[k] = 0;
      end else if (load) begin
        lv = int'(load_val) & c_mask[k];
        m_q[k] = (lv > c_mod[k] - 1) ? c_mod[k] - 1 : lv;
      end else if (en && up_dn) begin
        if (m_q[k] != c_mod[k] - 1) m_q[k] = m_q[k] + 1;
        else if (c_sat[k] == 0) begin m_q[k] = 0; m_wrap[k] = 1; end
      end else if (en) begin
        if (m_q[k] != 0) m_q[k] = m_q[k] - 1;
        else if (c_sat[k] == 0) begin m_q[k] = c_mod[k] - 1; m_wrap[k] = 1; end
      end
    end
  endtask

  // One clock: tc checked mid-cycle against pre-edge state, then q/qb/wrap after the edge.
  task automatic step(input string tag);
    @(negedge clk);
    check({tag, "_tc8"},   int'(tc8),   model_tc(0));
    check({tag, "_tc10w"}, int'(tc10w), model_tc(1));
    check({tag, "_tc10s"}, int'(tc10s), model_tc(2));
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_q8"},      int'(q8),      m_q[0]);
    check({tag, "_qb8"},     int'(qb8),     (~m_q[0]) & 255);
    check({tag, "_wrap8"},   int'(wrap8),   m_wrap[0]);
    check({tag, "_q10w"},    int'(q10w),    m_q[1]);
    check({tag, "_qb10w"},   int'(qb10w),   (~m_q[1]) & 15);
    check({tag, "_wrap10w"}, int'(wrap10w), m_wrap[1]);
    check({tag, "_q10s"},    int'(q10s),    m_q[2]);
    check({tag, "_wrap10s"}, int'(wrap10s), m_wrap[2]);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_q[k] = 0; m_wrap[k] = 0; end
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = 8'h00;
    step("rst0");
    check("h_rst0_q8", int'(q8), 0);
    check("h_rst0_qb8", int'(qb8), 8'hFF);
    check("h_rst0_wrap8", int'(wrap8), 0);

    // Reset mid-count with en high
    rst = 1'b0; load = 1'b1; load_val = 8'h5A;
    step("ld5a");
    check("h_ld5a_q8", int'(q8), 8'h5A);
    load = 1'b0; en = 1'b1; up_dn = 1'b1; rst = 1'b1;
    step("rst1");
    check("h_rst1_q8", int'(q8), 0);
    check("h_rst1_qb8", int'(qb8), 8'hFF);
    rst = 1'b0; en = 1'b0;
    step("rst1b");
    check("h_rst1b_wrap8", int'(wrap8), 0);

    // Power-of-2 up wrap
    load = 1'b1; load_val = 8'hFE;
    step("ldfe");
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step("upff");
    check("h_upff_q8", int'(q8), 8'hFF);
    #0 check("h_upff_tc8", int'(tc8), 1);
    step("up00");
    check("h_up00_q8", int'(q8), 0);
    check("h_up00_wrap8", int'(wrap8), 1);
    en = 1'b0;
    step("hold");
    check("h_hold_wrap8", int'(wrap8), 0);
    check("h_hold_q8", int'(q8), 0);

    // Non-power-of-2 down wrap
    load = 1'b1; load_val = 8'd1;
    step("ld1");
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step("dn0");
    check("h_dn0_q10w", int'(q10w), 0);
    check("h_dn0_tc10w", int'(tc10w), 1);
    step("dn9");
    check("h_dn9_q10w", int'(q10w), 9);
    check("h_dn9_wrap10w", int'(wrap10w), 1);
    check("h_dn9_tc10w", int'(tc10w), 0);

    // Saturate at top
    load = 1'b1; load_val = 8'd9;
    step("ld9");
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("sat");
      check("h_sat_q10s", int'(q10s), 9);
      check("h_sat_wrap10s", int'(wrap10s), 0);
      check("h_sat_tc10s", int'(tc10s), 1);
    end

    // Load, clamp, reset-over-load
    load = 1'b1; load_val = 8'd7; en = 1'b1;
    step("ld7");
    check("h_ld7_q10w", int'(q10w), 7);
    load_val = 8'd12;
    step("ld12");
    check("h_ld12_q10w", int'(q10w), 9);
    check("h_ld12_q8", int'(q8), 12);
    load_val = 8'd5; rst = 1'b1;
    step("ldrst");
    check("h_ldrst_q10w", int'(q10w), 0);
    check("h_ldrst_q8", int'(q8), 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom);
      load_val = 8'($urandom);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
